// File: rtl/mem_stage_hs_pkg.sv
// mem_pkg: memory command encodings, command decode helpers and the mem_stage_hs FSM state type
package mem_pkg;
  typedef enum logic [3:0] {
    MEM_NONE = 4'd0,
    MEM_LB   = 4'd1,
    MEM_LH   = 4'd2,
    MEM_LW   = 4'd3,
    MEM_LBU  = 4'd4,
    MEM_LHU  = 4'd5,
    MEM_LWU  = 4'd6,
    MEM_LD   = 4'd7,
    MEM_SB   = 4'd8,
    MEM_SH   = 4'd9,
    MEM_SW   = 4'd10,
    MEM_SD   = 4'd11
  } mem_cmd_e;
  typedef enum logic {IDLE, RESP} state_e;
  function automatic logic is_load(input logic [3:0] c, input logic w64);
    return c inside {MEM_LB, MEM_LH, MEM_LW, MEM_LBU, MEM_LHU} || (w64 && c inside {MEM_LWU, MEM_LD});
  endfunction
  function automatic logic is_store(input logic [3:0] c, input logic w64);
    return c inside {MEM_SB, MEM_SH, MEM_SW} || (w64 && c == MEM_SD);
  endfunction
  function automatic logic is_signed_load(input logic [3:0] c);
    return c inside {MEM_LB, MEM_LH, MEM_LW};
  endfunction
  function automatic logic [1:0] acc_size(input logic [3:0] c);
    return c inside {MEM_LB, MEM_LBU, MEM_SB} ? 2'd0 :
           c inside {MEM_LH, MEM_LHU, MEM_SH} ? 2'd1 :
           c inside {MEM_LD, MEM_SD}          ? 2'd3 : 2'd2;
  endfunction
endpackage

// File: rtl/mem_stage_hs_if.sv
// mem_stage_hs_if: EX_MEM inputs, DM request/response and MEM result bundle; master = memory stage, slave = its environment
interface mem_stage_hs_if #(parameter int DATA_W = 32, parameter int ADDR_W = 32);
  logic                EX_MEM_vld;
  logic [3:0]          EX_MEM_mem_cmd;
  logic [ADDR_W-1:0]   EX_MEM_alu_res;
  logic [DATA_W-1:0]   EX_MEM_mem_din;
  logic                MEM_stall;
  logic                DM_req;
  logic                DM_we;
  logic [DATA_W/8-1:0] DM_be;
  logic [ADDR_W-1:0]   DM_addr;
  logic [DATA_W-1:0]   DM_wdata;
  logic                DM_ack;
  logic                DM_rvalid;
  logic [DATA_W-1:0]   DM_rdata;
  logic                MEM_vld;
  logic [DATA_W-1:0]   MEM_data;
  logic                MEM_exc;
  modport master (
    input  EX_MEM_vld, EX_MEM_mem_cmd, EX_MEM_alu_res, EX_MEM_mem_din, DM_ack, DM_rvalid, DM_rdata,
    output MEM_stall, DM_req, DM_we, DM_be, DM_addr, DM_wdata, MEM_vld, MEM_data, MEM_exc
  );
  modport slave (
    output EX_MEM_vld, EX_MEM_mem_cmd, EX_MEM_alu_res, EX_MEM_mem_din, DM_ack, DM_rvalid, DM_rdata,
    input  MEM_stall, DM_req, DM_we, DM_be, DM_addr, DM_wdata, MEM_vld, MEM_data, MEM_exc
  );
endinterface

// File: rtl/mem_stage_hs_load_align.sv
// mem_load_align: selects the byte/half/word/dword lane of rdata at off (size sz) and sign- or zero-extends it to DATA_W
module mem_load_align #(
  parameter int DATA_W = 32,
  localparam int OW = $clog2(DATA_W/8)
) (
  input  logic [DATA_W-1:0] rdata,
  input  logic [OW-1:0]     off,
  input  logic [1:0]        sz,
  input  logic              sgn,
  output logic [DATA_W-1:0] data
);
  logic [DATA_W-1:0] lane, up;
  logic signed [DATA_W-1:0] s;
  logic [7:0] sh;
  always_comb begin
    lane = rdata >> {off, 3'b000};
    sh = 8'(DATA_W - (8 << sz));
    up = lane << sh;
    s = $signed(up) >>> sh;
    data = sgn ? $unsigned(s) : up >> sh;
  end
endmodule

// File: rtl/mem_stage_hs.sv
// mem_stage_hs: handshaked memory stage (clk, rst, bus: EX_MEM in, DM req/ack/rvalid, registered MEM_vld/data/exc); define MEM_MISALIGN_TRAP_EN to trap misaligned accesses
module mem_stage_hs
  import mem_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
) (
  input logic           clk,
  input logic           rst,
  mem_stage_hs_if.master bus
);
  localparam int BW = DATA_W/8;
  localparam int OW = $clog2(BW);
  localparam logic W64 = DATA_W == 64;
  state_e state;
  logic ld, st, mem_op, trap, req, done, fin;
  logic [1:0] sz;
  logic [OW-1:0] off, sz_mask;
  logic [BW-1:0] be_mask;
  logic [DATA_W-1:0] wdata, ld_data;
  always_comb begin
    ld = is_load(bus.EX_MEM_mem_cmd, W64);
    st = is_store(bus.EX_MEM_mem_cmd, W64);
    sz = acc_size(bus.EX_MEM_mem_cmd);
    sz_mask = OW'((32'd1 << sz) - 32'd1);
    off = bus.EX_MEM_alu_res[OW-1:0] & ~sz_mask;
    be_mask = ~({BW{1'b1}} << (32'd1 << sz));
    mem_op = !rst && bus.EX_MEM_vld && (ld || st);
`ifdef MEM_MISALIGN_TRAP_EN
    trap = mem_op && state == IDLE && |(bus.EX_MEM_alu_res[OW-1:0] & sz_mask);
`else
    trap = 1'b0;
`endif
    req = mem_op && !trap && state == IDLE;
    done = (req && st && bus.DM_ack) || (!rst && state == RESP && bus.DM_rvalid);
    fin = done || trap || (!rst && bus.EX_MEM_vld && bus.EX_MEM_mem_cmd == MEM_NONE);
    wdata = '0;
    for (int i = 0; i < BW; i++) wdata[8*i +: 8] = bus.EX_MEM_mem_din[8*(i & ((1 << sz) - 1)) +: 8];
    bus.MEM_stall = mem_op && !done && !trap;
    bus.DM_req = req;
    bus.DM_we = req && st;
    bus.DM_be = (req && st) ? be_mask << off : '0;
    bus.DM_addr = req ? {bus.EX_MEM_alu_res[ADDR_W-1:OW], OW'(0)} : '0;
    bus.DM_wdata = (req && st) ? wdata : '0;
  end
  mem_load_align #(.DATA_W(DATA_W)) u_align (
    .rdata (bus.DM_rdata),
    .off   (off),
    .sz    (sz),
    .sgn   (is_signed_load(bus.EX_MEM_mem_cmd)),
    .data  (ld_data)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      bus.MEM_vld <= 1'b0;
      bus.MEM_data <= '0;
      bus.MEM_exc <= 1'b0;
    end else begin
      state <= (state == IDLE && req && ld && bus.DM_ack) ? RESP : (state == RESP && bus.DM_rvalid) ? IDLE : state;
      bus.MEM_vld <= fin;
      bus.MEM_exc <= trap;
      if (fin) bus.MEM_data <= (ld && !trap) ? ld_data : DATA_W'(bus.EX_MEM_alu_res);
    end
  end
endmodule

// File: tb/tb_mem_stage_hs.sv
// tb_mem_stage_hs: directed self-checking bench for mem_stage_hs in 32- and 64-bit builds
module tb_mem_stage_hs;
  import mem_pkg::*;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_chk = 0;
  int n_fail = 0;
  always #5 clk = ~clk;
  mem_stage_hs_if #(.DATA_W(32), .ADDR_W(32)) b32();
  mem_stage_hs_if #(.DATA_W(64), .ADDR_W(32)) b64();
  mem_stage_hs #(.DATA_W(32), .ADDR_W(32)) u32 (.clk(clk), .rst(rst), .bus(b32));
  mem_stage_hs #(.DATA_W(64), .ADDR_W(32)) u64 (.clk(clk), .rst(rst), .bus(b64));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_all();
    b32.EX_MEM_vld = 0; b32.EX_MEM_mem_cmd = MEM_NONE; b32.EX_MEM_alu_res = '0; b32.EX_MEM_mem_din = '0;
    b32.DM_ack = 0; b32.DM_rvalid = 0; b32.DM_rdata = '0;
    b64.EX_MEM_vld = 0; b64.EX_MEM_mem_cmd = MEM_NONE; b64.EX_MEM_alu_res = '0; b64.EX_MEM_mem_din = '0;
    b64.DM_ack = 0; b64.DM_rvalid = 0; b64.DM_rdata = '0;
  endtask

  task automatic test_reset();
    idle_all();
    rst = 1;
    b32.EX_MEM_vld = 1; b32.EX_MEM_mem_cmd = MEM_LW; b32.EX_MEM_alu_res = 32'h200; b32.DM_rvalid = 1;
    step(); step();
    if (b32.MEM_vld !== 1'b0) begin n_fail++; $display("FAIL reset_vld: got %b want 0", b32.MEM_vld); end
    n_chk++;
    if (b32.MEM_data !== 32'h0) begin n_fail++; $display("FAIL reset_data: got %h want 0", b32.MEM_data); end
    n_chk++;
    if (b32.MEM_exc !== 1'b0) begin n_fail++; $display("FAIL reset_exc: got %b want 0", b32.MEM_exc); end
    n_chk++;
    if ({b32.MEM_stall, b32.DM_req, b32.DM_we} !== 3'b000) begin
      n_fail++; $display("FAIL reset_comb: stall/req/we got %b want 000", {b32.MEM_stall, b32.DM_req, b32.DM_we});
    end
    n_chk++;
    rst = 0;
    b32.EX_MEM_vld = 0;
    step();
    b32.DM_rvalid = 0;
    if (b32.MEM_vld !== 1'b0) begin n_fail++; $display("FAIL idle_rvalid_dropped: MEM_vld got %b want 0", b32.MEM_vld); end
    n_chk++;
  endtask

  task automatic test_none();
    b32.EX_MEM_vld = 1; b32.EX_MEM_mem_cmd = MEM_NONE; b32.EX_MEM_alu_res = 32'h1234;
    #1;
    if (b32.MEM_stall !== 1'b0) begin n_fail++; $display("FAIL none_stall: got %b want 0", b32.MEM_stall); end
    n_chk++;
    step();
    b32.EX_MEM_vld = 0;
    if ({b32.MEM_vld, b32.MEM_data} !== {1'b1, 32'h1234}) begin
      n_fail++; $display("FAIL none_result: vld=%b data=%h want vld=1 data=00001234", b32.MEM_vld, b32.MEM_data);
    end
    n_chk++;
    step();
    if (b32.MEM_vld !== 1'b0) begin n_fail++; $display("FAIL none_pulse: MEM_vld got %b want 0", b32.MEM_vld); end
    n_chk++;
  endtask

  task automatic do_store(input logic [3:0] cmd, input logic [31:0] addr, input logic [31:0] din,
                          input int wait_cyc, input logic [3:0] ebe, input logic [31:0] ewd, input string nm);
    b32.EX_MEM_vld = 1; b32.EX_MEM_mem_cmd = cmd; b32.EX_MEM_alu_res = addr; b32.EX_MEM_mem_din = din; b32.DM_ack = 0;
    for (int i = 0; i < wait_cyc; i++) begin
      #1;
      if ({b32.MEM_stall, b32.DM_req, b32.DM_we} !== 3'b111) begin
        n_fail++; $display("FAIL %s_wait%0d_ctl: stall/req/we got %b want 111", nm, i, {b32.MEM_stall, b32.DM_req, b32.DM_we});
      end
      n_chk++;
      if ({b32.DM_be, b32.DM_wdata, b32.DM_addr} !== {ebe, ewd, addr[31:2], 2'b00}) begin
        n_fail++; $display("FAIL %s_wait%0d_bus: be=%b wdata=%h addr=%h want be=%b wdata=%h addr=%h",
                           nm, i, b32.DM_be, b32.DM_wdata, b32.DM_addr, ebe, ewd, {addr[31:2], 2'b00});
      end
      n_chk++;
      step();
    end
    b32.DM_ack = 1;
    #1;
    if ({b32.MEM_stall, b32.DM_req, b32.DM_be, b32.DM_wdata} !== {1'b0, 1'b1, ebe, ewd}) begin
      n_fail++; $display("FAIL %s_ack: stall=%b req=%b be=%b wdata=%h want 0 1 %b %h",
                         nm, b32.MEM_stall, b32.DM_req, b32.DM_be, b32.DM_wdata, ebe, ewd);
    end
    n_chk++;
    step();
    b32.DM_ack = 0; b32.EX_MEM_vld = 0;
    if ({b32.MEM_vld, b32.MEM_data, b32.MEM_exc} !== {1'b1, addr, 1'b0}) begin
      n_fail++; $display("FAIL %s_result: vld=%b data=%h exc=%b want 1 %h 0", nm, b32.MEM_vld, b32.MEM_data, b32.MEM_exc, addr);
    end
    n_chk++;
    step();
    if (b32.MEM_vld !== 1'b0) begin n_fail++; $display("FAIL %s_pulse: MEM_vld got %b want 0", nm, b32.MEM_vld); end
    n_chk++;
  endtask

  task automatic do_load(input logic [3:0] cmd, input logic [31:0] addr, input logic [31:0] rdata,
                         input int gap, input logic [31:0] exp, input string nm);
    b32.EX_MEM_vld = 1; b32.EX_MEM_mem_cmd = cmd; b32.EX_MEM_alu_res = addr; b32.DM_ack = 1;
    #1;
    if ({b32.MEM_stall, b32.DM_req, b32.DM_we, b32.DM_be} !== {3'b110, 4'b0000}) begin
      n_fail++; $display("FAIL %s_req: stall/req/we/be got %b want 1100000", nm, {b32.MEM_stall, b32.DM_req, b32.DM_we, b32.DM_be});
    end
    n_chk++;
    if (b32.DM_addr !== {addr[31:2], 2'b00}) begin
      n_fail++; $display("FAIL %s_addr: got %h want %h", nm, b32.DM_addr, {addr[31:2], 2'b00});
    end
    n_chk++;
    step();
    b32.DM_ack = 0;
    for (int i = 1; i < gap; i++) begin
      #1;
      if ({b32.MEM_stall, b32.DM_req, b32.MEM_vld} !== 3'b100) begin
        n_fail++; $display("FAIL %s_resp%0d: stall/req/vld got %b want 100", nm, i, {b32.MEM_stall, b32.DM_req, b32.MEM_vld});
      end
      n_chk++;
      step();
    end
    b32.DM_rvalid = 1; b32.DM_rdata = rdata;
    #1;
    if (b32.MEM_stall !== 1'b0) begin n_fail++; $display("FAIL %s_rvalid_stall: got %b want 0", nm, b32.MEM_stall); end
    n_chk++;
    step();
    b32.DM_rvalid = 0; b32.EX_MEM_vld = 0;
    if ({b32.MEM_vld, b32.MEM_data, b32.MEM_exc} !== {1'b1, exp, 1'b0}) begin
      n_fail++; $display("FAIL %s_result: vld=%b data=%h exc=%b want 1 %h 0", nm, b32.MEM_vld, b32.MEM_data, b32.MEM_exc, exp);
    end
    n_chk++;
    step();
    if (b32.MEM_vld !== 1'b0) begin n_fail++; $display("FAIL %s_pulse: MEM_vld got %b want 0", nm, b32.MEM_vld); end
    n_chk++;
  endtask

  task automatic test_store();
    do_store(MEM_SB, 32'h103, 32'h000000AB, 3, 4'b1000, 32'hABABABAB, "sb");
    do_store(MEM_SH, 32'h102, 32'h00001234, 1, 4'b1100, 32'h12341234, "sh");
    do_store(MEM_SW, 32'h104, 32'hDEADBEEF, 0, 4'b1111, 32'hDEADBEEF, "sw");
  endtask

  task automatic test_load();
    do_load(MEM_LH, 32'h102, 32'h80010000, 2, 32'hFFFF8001, "lh");
    do_load(MEM_LHU, 32'h102, 32'h80010000, 2, 32'h00008001, "lhu");
    do_load(MEM_LB, 32'h103, 32'h80000000, 1, 32'hFFFFFF80, "lb");
    do_load(MEM_LBU, 32'h103, 32'h80000000, 3, 32'h00000080, "lbu");
    do_load(MEM_LB, 32'h101, 32'h00007F00, 1, 32'h0000007F, "lb_pos");
  endtask

  task automatic test_misalign();
`ifdef MEM_MISALIGN_TRAP_EN
    b32.EX_MEM_vld = 1; b32.EX_MEM_mem_cmd = MEM_LW; b32.EX_MEM_alu_res = 32'h101; b32.DM_ack = 0;
    #1;
    if ({b32.DM_req, b32.MEM_stall} !== 2'b00) begin
      n_fail++; $display("FAIL trap_req: req/stall got %b want 00", {b32.DM_req, b32.MEM_stall});
    end
    n_chk++;
    step();
    b32.EX_MEM_vld = 0;
    if ({b32.MEM_vld, b32.MEM_exc, b32.MEM_data} !== {2'b11, 32'h101}) begin
      n_fail++; $display("FAIL trap_result: vld=%b exc=%b data=%h want 1 1 00000101", b32.MEM_vld, b32.MEM_exc, b32.MEM_data);
    end
    n_chk++;
    step();
    if ({b32.MEM_vld, b32.MEM_exc} !== 2'b00) begin
      n_fail++; $display("FAIL trap_pulse: vld/exc got %b want 00", {b32.MEM_vld, b32.MEM_exc});
    end
    n_chk++;
`else
    do_load(MEM_LW, 32'h101, 32'h12345678, 1, 32'h12345678, "lw_mis");
    do_store(MEM_SH, 32'h103, 32'h0000BEEF, 0, 4'b1100, 32'hBEEFBEEF, "sh_mis");
`endif
  endtask

  task automatic test_illegal();
    logic [3:0] codes [2] = '{4'd12, MEM_LD};
    foreach (codes[k]) begin
      b32.EX_MEM_vld = 1; b32.EX_MEM_mem_cmd = codes[k]; b32.EX_MEM_alu_res = 32'h77;
      #1;
      if ({b32.MEM_stall, b32.DM_req} !== 2'b00) begin
        n_fail++; $display("FAIL illegal%0d_comb: stall/req got %b want 00", k, {b32.MEM_stall, b32.DM_req});
      end
      n_chk++;
      step();
      b32.EX_MEM_vld = 0;
      if (b32.MEM_vld !== 1'b0) begin n_fail++; $display("FAIL illegal%0d_vld: got %b want 0", k, b32.MEM_vld); end
      n_chk++;
    end
  endtask

  task automatic test_reset_mid();
    b32.EX_MEM_vld = 1; b32.EX_MEM_mem_cmd = MEM_LW; b32.EX_MEM_alu_res = 32'h200; b32.DM_ack = 1;
    step();
    b32.DM_ack = 0;
    #1;
    if (b32.MEM_stall !== 1'b1) begin n_fail++; $display("FAIL rmid_resp_stall: got %b want 1", b32.MEM_stall); end
    n_chk++;
    step();
    rst = 1; b32.EX_MEM_vld = 0;
    #1;
    if ({b32.DM_req, b32.MEM_stall} !== 2'b00) begin
      n_fail++; $display("FAIL rmid_rst_comb: req/stall got %b want 00", {b32.DM_req, b32.MEM_stall});
    end
    n_chk++;
    step();
    rst = 0;
    if (b32.MEM_vld !== 1'b0) begin n_fail++; $display("FAIL rmid_no_result: MEM_vld got %b want 0", b32.MEM_vld); end
    n_chk++;
    b32.DM_rvalid = 1; b32.DM_rdata = 32'hCAFEBABE;
    step();
    b32.DM_rvalid = 0;
    if (b32.MEM_vld !== 1'b0) begin n_fail++; $display("FAIL rmid_stale_rvalid: MEM_vld got %b want 0", b32.MEM_vld); end
    n_chk++;
    b32.EX_MEM_vld = 1; b32.EX_MEM_mem_cmd = MEM_NONE; b32.EX_MEM_alu_res = 32'h55;
    step();
    b32.EX_MEM_vld = 0;
    if ({b32.MEM_vld, b32.MEM_data} !== {1'b1, 32'h55}) begin
      n_fail++; $display("FAIL rmid_none: vld=%b data=%h want 1 00000055", b32.MEM_vld, b32.MEM_data);
    end
    n_chk++;
    step();
    do_load(MEM_LW, 32'h204, 32'h0BADF00D, 1, 32'h0BADF00D, "rmid_lw");
  endtask

  task automatic test_back_to_back();
    b32.EX_MEM_vld = 1; b32.EX_MEM_mem_cmd = MEM_SW; b32.EX_MEM_alu_res = 32'h300; b32.EX_MEM_mem_din = 32'h11223344; b32.DM_ack = 1;
    step();
    b32.EX_MEM_mem_cmd = MEM_LB; b32.EX_MEM_alu_res = 32'h301;
    #1;
    if ({b32.DM_req, b32.DM_we, b32.MEM_vld, b32.MEM_data} !== {3'b101, 32'h300}) begin
      n_fail++; $display("FAIL b2b_issue: req=%b we=%b vld=%b data=%h want 1 0 1 00000300",
                         b32.DM_req, b32.DM_we, b32.MEM_vld, b32.MEM_data);
    end
    n_chk++;
    step();
    b32.DM_ack = 0; b32.DM_rvalid = 1; b32.DM_rdata = 32'h0000FE00;
    step();
    b32.DM_rvalid = 0;
    b32.EX_MEM_mem_cmd = MEM_NONE; b32.EX_MEM_alu_res = 32'h9;
    if ({b32.MEM_vld, b32.MEM_data} !== {1'b1, 32'hFFFFFFFE}) begin
      n_fail++; $display("FAIL b2b_load: vld=%b data=%h want 1 fffffffe", b32.MEM_vld, b32.MEM_data);
    end
    n_chk++;
    step();
    b32.EX_MEM_vld = 0;
    if ({b32.MEM_vld, b32.MEM_data} !== {1'b1, 32'h9}) begin
      n_fail++; $display("FAIL b2b_none: vld=%b data=%h want 1 00000009", b32.MEM_vld, b32.MEM_data);
    end
    n_chk++;
    step();
  endtask

  task automatic test_wide();
    logic [3:0]  lcmd [2] = '{MEM_LWU, MEM_LW};
    logic [63:0] lexp [2] = '{64'h00000000F0000001, 64'hFFFFFFFFF0000001};
    foreach (lcmd[k]) begin
      b64.EX_MEM_vld = 1; b64.EX_MEM_mem_cmd = lcmd[k]; b64.EX_MEM_alu_res = 32'h4; b64.DM_ack = 1;
      #1;
      if ({b64.DM_req, b64.DM_addr, b64.DM_be} !== {1'b1, 32'h0, 8'h00}) begin
        n_fail++; $display("FAIL w64_ld%0d_req: req=%b addr=%h be=%h want 1 00000000 00", k, b64.DM_req, b64.DM_addr, b64.DM_be);
      end
      n_chk++;
      step();
      b64.DM_ack = 0; b64.DM_rvalid = 1; b64.DM_rdata = 64'hF000_0001_0000_0000;
      step();
      b64.DM_rvalid = 0; b64.EX_MEM_vld = 0;
      if ({b64.MEM_vld, b64.MEM_data} !== {1'b1, lexp[k]}) begin
        n_fail++; $display("FAIL w64_ld%0d_result: vld=%b data=%h want 1 %h", k, b64.MEM_vld, b64.MEM_data, lexp[k]);
      end
      n_chk++;
      step();
    end
    b64.EX_MEM_vld = 1; b64.EX_MEM_mem_cmd = MEM_SD; b64.EX_MEM_alu_res = 32'h8;
    b64.EX_MEM_mem_din = 64'h0123456789ABCDEF; b64.DM_ack = 1;
    #1;
    if ({b64.DM_be, b64.DM_wdata, b64.DM_addr} !== {8'hFF, 64'h0123456789ABCDEF, 32'h8}) begin
      n_fail++; $display("FAIL w64_sd_bus: be=%h wdata=%h addr=%h want ff 0123456789abcdef 00000008", b64.DM_be, b64.DM_wdata, b64.DM_addr);
    end
    n_chk++;
    step();
    b64.EX_MEM_mem_cmd = MEM_SW; b64.EX_MEM_alu_res = 32'hC; b64.EX_MEM_mem_din = 64'hCAFEF00D;
    if ({b64.MEM_vld, b64.MEM_data} !== {1'b1, 64'h8}) begin
      n_fail++; $display("FAIL w64_sd_result: vld=%b data=%h want 1 0000000000000008", b64.MEM_vld, b64.MEM_data);
    end
    n_chk++;
    #1;
    if ({b64.DM_be, b64.DM_wdata, b64.DM_addr} !== {8'hF0, 64'hCAFEF00DCAFEF00D, 32'h8}) begin
      n_fail++; $display("FAIL w64_sw_bus: be=%h wdata=%h addr=%h want f0 cafef00dcafef00d 00000008", b64.DM_be, b64.DM_wdata, b64.DM_addr);
    end
    n_chk++;
    step();
    b64.EX_MEM_vld = 0; b64.DM_ack = 0;
    step();
  endtask

  initial begin
    test_reset();
    test_none();
    test_store();
    test_load();
    test_misalign();
    test_illegal();
    test_reset_mid();
    test_back_to_back();
    test_wide();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/mem_stage_hs.md
# mem_stage_hs

Parametrised, handshaked memory-access stage for the in-order pipeline. Sits between EX/MEM and MEM/WB like the current single-cycle memory stage, but talks to a variable-latency data memory over a request/acknowledge plus response-valid protocol, stalls upstream while an access is outstanding, and registers its result. It also generates store byte enables, supports 32- or 64-bit datapaths and optionally traps misaligned accesses.

## Interface
Parameters:
- DATA_W, 32, datapath width; 32 or 64 only.
- ADDR_W, 32, address width.

Ports:
- clk  in  1  clock; the only clock.
- rst  in  1  reset; synchronous, active-high.
- EX_MEM_vld  in  1  upstream instruction valid.
- EX_MEM_mem_cmd  in  4  memory command (`MEM_*` encodings).
- EX_MEM_alu_res  in  ADDR_W  effective address, or ALU result for non-memory ops.
- EX_MEM_mem_din  in  DATA_W  store data, LSB-aligned.
- MEM_stall  out  1  hold EX_MEM_* stable this cycle.
- DM_req  out  1  memory request.
- DM_we  out  1  1 for store.
- DM_be  out  DATA_W/8  byte enables.
- DM_addr  out  ADDR_W  address, low log2(DATA_W/8) bits zeroed.
- DM_wdata  out  DATA_W  store data replicated into all lanes.
- DM_ack  in  1  request accepted this cycle.
- DM_rvalid  in  1  load data valid.
- DM_rdata  in  DATA_W  load data, full word.
- MEM_vld  out  1  registered result valid.
- MEM_data  out  DATA_W  registered result.
- MEM_exc  out  1  registered misalign exception flag.

## Operation
- Commands: LB, LH, LW, LBU, LHU, SB, SH, SW, NONE. With DATA_W=64 also LWU, LD, SD. Any other code is illegal: no access, no stall, no result.
- FSM states:
  - IDLE: DM_req = EX_MEM_vld & memory cmd & aligned.
    - DM_ack on a store: completes this cycle.
    - DM_ack on a load: go to RESP.
  - RESP: DM_req=0; wait for DM_rvalid. On DM_rvalid the load completes and the FSM returns to IDLE.
- MEM_stall = EX_MEM_vld & memory cmd & not completing this cycle. Non-memory ops never stall.
- Byte offset = addr[log2(DATA_W/8)-1:0].
  - DM_be: SB = 1<<off, SH = 3<<off, SW = 0xF<<off, SD = all ones.
  - Loads: zero DM_be; DM_we=0.
- Load result: select byte/half/word lane from DM_rdata by offset, then sign-extend (LB/LH/LW) or zero-extend (LBU/LHU/LWU) to DATA_W. LD passes the word through.
- Stores and NONE return EX_MEM_alu_res, zero-extended to DATA_W.
- DM_rvalid in IDLE is ignored and dropped.

## Timing
- Reset: state=IDLE; MEM_vld=0, MEM_data=0, MEM_exc=0.
- Combinational outputs (MEM_stall, DM_*) are 0 while rst is high.
- Latency to MEM_vld:
  - NONE: 1 cycle.
  - Store: the cycle after DM_ack (1 cycle if acked immediately).
  - Load: the cycle after DM_rvalid (minimum 2 cycles).
- MEM_vld is a one-cycle pulse per completed instruction. It is 0 in any cycle with no completion.
- DM_req, DM_addr, DM_be, DM_wdata and DM_we stay stable from assertion until DM_ack.
- Back-to-back: a new request may issue in the cycle after a store ack, or after the load's DM_rvalid cycle.
- Reset mid-access: FSM aborts to IDLE and no result is produced. A stale DM_rvalid arriving afterwards is dropped.

## Configuration
- MEM_MISALIGN_TRAP_EN defined:
  - Misaligned H/W/D access (offset not a multiple of the access size) issues no DM_req and does not stall.
  - Next cycle: MEM_vld=1, MEM_exc=1, MEM_data = faulting address.
- Undefined: low address bits are forced to natural alignment, the access proceeds normally, and MEM_exc is tied 0.

## Structure
- Shared package mem_pkg holds:
  - command encodings, replacing the `MEM_*` defines, including LWU/LD/SD;
  - the is_load/is_store/access-size helper functions;
  - the FSM state enum {IDLE, RESP}.
- One sub-module, mem_load_align: combinational lane select plus sign/zero extension, parametrised by DATA_W.

## Test plan
- NONE, alu_res=0x1234 -> next cycle MEM_vld=1, MEM_data=0x1234, MEM_stall never high.
- SB addr=0x103, din=0xAB, DM_ack after 3 cycles -> DM_be=4'b1000, DM_wdata=0xABABABAB, MEM_stall high 3 cycles, MEM_vld pulse with data 0x103.
- LH addr=0x102, DM_rdata=0x8001_0000, rvalid 2 cycles after ack -> MEM_data=0xFFFF8001. Same access with LHU -> 0x00008001.
- LW with TRAP_EN, addr=0x101 -> DM_req never asserted, MEM_exc=1, MEM_data=0x101. Without TRAP_EN -> DM_addr=0x100.
- rst asserted while in RESP, then DM_rvalid -> no MEM_vld, FSM in IDLE, next NONE completes in 1 cycle.
- DATA_W=64: LWU addr=0x4, DM_rdata=0xF000_0001_0000_0000 -> MEM_data=0x0000_0000_F000_0001.
